// File: rtl/fsm_seq_pkg.sv
// Shared types, table-entry layout and LFSR helpers for the FSM vector sequencer.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ENTRY_W = 6;
    localparam int unsigned NS_HI   = 5;
    localparam int unsigned NS_LO   = 4;
    localparam int unsigned OUT_HI  = 3;
    localparam int unsigned OUT_LO  = 0;

    // Right-shifting form of the x^8+x^6+x^5+x^4+1 taps (8'hB8 in left-shift form).
    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {^(l & LFSR_TAPS), l[7:1]};
    endfunction

    function automatic logic [1:0] entry_ns(input entry_t e);
        return e[NS_HI:NS_LO];
    endfunction

    function automatic logic [3:0] entry_out(input entry_t e);
        return e[OUT_HI:OUT_LO];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit right-shifting Fibonacci LFSR with synchronous load and advance.
module lfsr8
    import fsm_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/fsm_vector_sequencer.sv
// Drives table-derived stimulus into a 4-state Mealy FSM and counts output mismatches.
module fsm_vector_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [5:0]   cfg_data,
    input  logic         start,
    output logic [1:0]   in_o,
    output logic [1:0]   cs_o,
    output logic [1:0]   ns_o,
    output logic [3:0]   exp_out_o,
    input  logic [3:0]   dut_out,
    output logic         busy,
    output logic         done,
    output logic [7:0]   err_count,
    output logic         pass
);

    localparam logic [9:0] LAST_STEP = 10'(NUM_VECTORS - 1);

    state_t      state;
    state_t      state_next;
    entry_t      tbl [16];
    entry_t      entry;
    logic [9:0]  step;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic [7:0]  lfsr_val;
    logic [7:0]  lfsr_nxt;
    logic [5:0]  lfsr_nxt_unused;
    logic        mismatch;
    logic [7:0]  err_next;

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (SEED),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    lfsr_load  = 1'b1;
                end
            end
            RUN: begin
                busy     = 1'b1;
                lfsr_adv = 1'b1;
                if (step == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // Lookups are forced to zero outside RUN so idle outputs stay quiet.
    always_comb begin
        entry     = tbl[{cs_o, in_o}];
        ns_o      = busy ? entry_ns(entry)  : '0;
        exp_out_o = busy ? entry_out(entry) : '0;
        mismatch  = busy && (dut_out != exp_out_o);
        err_next  = (mismatch && err_count != '1) ? err_count + 8'd1 : err_count;
        lfsr_nxt  = lfsr_next(lfsr_val);
    end

    assign lfsr_nxt_unused = lfsr_nxt[7:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            in_o      <= '0;
            cs_o      <= '0;
            step      <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_o      <= SEED[1:0];
                        cs_o      <= '0;
                        step      <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    err_count <= err_next;
                    step      <= step + 10'd1;
                    // Verdict is taken on the closing edge so it is valid during the done pulse.
                    if (step == LAST_STEP) begin
                        in_o <= '0;
                        cs_o <= '0;
                        pass <= (err_next == '0);
                    end else begin
                        in_o <= lfsr_nxt[1:0];
                        cs_o <= ns_o;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Directed self-checking bench for fsm_vector_sequencer (default and 300-vector instances).
module tb_fsm_vector_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       start;
    logic [1:0] in_o, cs_o, ns_o;
    logic [3:0] exp_out_o;
    logic [3:0] dut_out;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] mode;

    logic       start_s;
    logic       cfg_we_s;
    logic [1:0] in_s, cs_s, ns_s;
    logic [3:0] exp_s;
    logic [3:0] dut_out_s;
    logic       busy_s, done_s, pass_s;
    logic [7:0] err_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fsm_vector_sequencer u_dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .in_o      (in_o),
        .cs_o      (cs_o),
        .ns_o      (ns_o),
        .exp_out_o (exp_out_o),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .pass      (pass)
    );

    fsm_vector_sequencer #(.NUM_VECTORS(300)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we_s),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start_s),
        .in_o      (in_s),
        .cs_o      (cs_s),
        .ns_o      (ns_s),
        .exp_out_o (exp_s),
        .dut_out   (dut_out_s),
        .busy      (busy_s),
        .done      (done_s),
        .err_count (err_s),
        .pass      (pass_s)
    );

    // 0: loopback, 1: stuck-at-zero, 2: ideal identity FSM out = {cs, in}
    always_comb begin
        case (mode)
            2'd0:    dut_out = exp_out_o;
            2'd1:    dut_out = 4'h0;
            default: dut_out = {cs_o, in_o};
        endcase
    end

    assign dut_out_s = 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_table(input bit stuck);
        logic [3:0] a;
        for (int i = 0; i < 16; i++) begin
            a        = 4'(i);
            cfg_we   = 1'b1;
            cfg_addr = a;
            cfg_data = stuck ? {a[1:0], 4'hF} : {a[1:0], a};
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input bit sat);
        if (sat) start_s = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    // Counts cycles since the start edge; first value 1 is the vector-0 cycle.
    task automatic wait_done(input bit sat, input int first, input int limit, output int cyc);
        cyc = first;
        while (!(sat ? done_s : done) && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    bit seen_done;
    logic [1:0] exp_in [5];
    logic [1:0] exp_cs [5];
    logic [3:0] exp_o  [5];

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; start_s = 1'b0; cfg_we_s = 1'b0; mode = 2'd0;

        // SEED A5 -> 52 -> A9 -> 54 -> 2A ; identity table makes cs(k+1) = in(k)
        exp_in[0] = 2'b01; exp_in[1] = 2'b10; exp_in[2] = 2'b01; exp_in[3] = 2'b00; exp_in[4] = 2'b10;
        exp_cs[0] = 2'b00; exp_cs[1] = 2'b01; exp_cs[2] = 2'b10; exp_cs[3] = 2'b01; exp_cs[4] = 2'b00;
        exp_o[0]  = 4'h1;  exp_o[1]  = 4'h6;  exp_o[2]  = 4'h9;  exp_o[3]  = 4'h4;  exp_o[4]  = 4'h2;

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err_count), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_in",   32'(in_o), 0);
        check("rst_cs",   32'(cs_o), 0);
        check("rst_ns",   32'(ns_o), 0);
        check("rst_exp",  32'(exp_out_o), 0);

        // Loopback with identity table, plus LFSR ordering of the first vectors
        load_table(1'b0);
        mode = 2'd0;
        start_run(1'b0);
        check("lb_busy_v0", 32'(busy), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check($sformatf("lfsr_in_v%0d", k),  32'(in_o),      32'(exp_in[k]));
            check($sformatf("cs_v%0d", k),       32'(cs_o),      32'(exp_cs[k]));
            check($sformatf("ns_v%0d", k),       32'(ns_o),      32'(exp_in[k]));
            check($sformatf("exp_out_v%0d", k),  32'(exp_out_o), 32'(exp_o[k]));
        end
        wait_done(1'b0, 5, 200, cyc);
        check("lb_done_cycle", 32'(cyc), 65);
        check("lb_busy_at_done", 32'(busy), 0);
        check("lb_err", 32'(err_count), 0);
        check("lb_pass", 32'(pass), 1);
        tick();
        check("lb_done_one_cycle", 32'(done), 0);
        check("lb_pass_hold", 32'(pass), 1);

        // Stuck-at fault: every vector expects F and sees 0
        load_table(1'b1);
        mode = 2'd1;
        start_run(1'b0);
        check("sa_err_v0", 32'(err_count), 0);
        wait_done(1'b0, 1, 200, cyc);
        check("sa_done_cycle", 32'(cyc), 65);
        check("sa_err", 32'(err_count), 64);
        check("sa_pass", 32'(pass), 0);
        tick();
        check("sa_err_hold", 32'(err_count), 64);

        // Ignored start and cfg_we mid-run; corrupted entries would break the ideal-FSM compare
        load_table(1'b0);
        mode = 2'd2;
        start_run(1'b0);
        cyc = 1;
        for (int i = 0; i < 10; i++) begin tick(); cyc++; end
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = 6'h3F;
            tick();
            cyc++;
            start = 1'b0;
        end
        cfg_we = 1'b0;
        wait_done(1'b0, cyc, 200, cyc);
        check("ign_done_cycle", 32'(cyc), 65);
        check("ign_err", 32'(err_count), 0);
        check("ign_pass", 32'(pass), 1);
        tick();
        check("ign_no_restart", 32'(busy), 0);
        start_run(1'b0);
        wait_done(1'b0, 1, 200, cyc);
        check("ign_table_kept_err", 32'(err_count), 0);
        check("ign_table_kept_cycle", 32'(cyc), 65);

        // Saturation on the 300-vector instance: zero table vs constant F
        tick();
        start_run(1'b1);
        check("sat_busy", 32'(busy_s), 1);
        wait_done(1'b1, 1, 600, cyc);
        check("sat_done_cycle", 32'(cyc), 301);
        check("sat_err", 32'(err_s), 255);
        check("sat_pass", 32'(pass_s), 0);

        // Reset at vector 20 aborts without a done pulse
        tick();
        mode = 2'd0;
        start_run(1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("mr_busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_in",   32'(in_o), 0);
        check("mr_cs",   32'(cs_o), 0);
        check("mr_ns",   32'(ns_o), 0);
        check("mr_exp",  32'(exp_out_o), 0);
        check("mr_err",  32'(err_count), 0);
        check("mr_pass", 32'(pass), 0);
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check("mr_no_done", 32'(seen_done), 0);
        load_table(1'b0);
        mode = 2'd2;
        start_run(1'b0);
        check("mr_rerun_in_v0", 32'(in_o), 1);
        wait_done(1'b0, 1, 200, cyc);
        check("mr_rerun_cycle", 32'(cyc), 65);
        check("mr_rerun_err", 32'(err_count), 0);
        check("mr_rerun_pass", 32'(pass), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
